// File: rtl/dpi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dpi_pkg : shared sizing defaults and FSM states for the DPI front end |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dpi_pkg;

   localparam int SID_W       = 6;
   localparam int NUM_STREAMS = 64;
   localparam int KEY_W       = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOOKUP = 3'd1,
      ST_LOAD   = 3'd2,
      ST_GAP    = 3'd3,
      ST_STREAM = 3'd4,
      ST_EOP    = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dpi_stream_dispatch_key_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_key_table : flow-key CAM with round-robin stream allocation    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module stream_key_table #(
   parameter int  KEY_W       = dpi_pkg::KEY_W,
   parameter int  NUM_STREAMS = dpi_pkg::NUM_STREAMS,
   localparam int SID_W       = $clog2(NUM_STREAMS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [KEY_W-1:0] i_key,
   output logic             o_hit,
   output logic [SID_W-1:0] o_hit_sid,
   output logic [SID_W-1:0] o_alloc_sid,
   input  logic             i_we,
   input  logic [SID_W-1:0] i_wsid,
   input  logic [KEY_W-1:0] i_wkey
);
   import dpi_pkg::*;

   logic [NUM_STREAMS-1:0] r_valid;
   logic [KEY_W-1:0]       r_keys [NUM_STREAMS];
   logic [SID_W-1:0]       r_alloc_ptr;
   logic [NUM_STREAMS-1:0] w_match;
   logic                   w_hit;
   logic [SID_W-1:0]       w_hit_sid;

   generate
      for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_cmp
         assign w_match[g] = r_valid[g] && (r_keys[g] == i_key);
      end
   endgenerate

   // Keys are unique, so at most one match bit is ever set.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_sid = '0;
      for (int i = 0; i < NUM_STREAMS; i++) begin
         if (w_match[i]) begin
            w_hit     = 1'b1;
            w_hit_sid = i[SID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid     <= '0;
         r_alloc_ptr <= '0;
      end else if (i_we) begin
         r_valid[i_wsid] <= 1'b1;
         if (r_alloc_ptr == SID_W'(NUM_STREAMS - 1))
            r_alloc_ptr <= '0;
         else
            r_alloc_ptr <= r_alloc_ptr + SID_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_we)
         r_keys[i_wsid] <= i_wkey;
   end

   assign o_hit       = w_hit;
   assign o_hit_sid   = w_hit_sid;
   assign o_alloc_sid = r_alloc_ptr;

endmodule
`default_nettype wire

// File: rtl/dpi_stream_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dpi_stream_dispatch : maps packets to stream IDs and sequences the    |
// | matcher load/stream/eop control.                       Rev 1.0       |
// +----------------------------------------------------------------------+
module dpi_stream_dispatch #(
   parameter int   KEY_W       = dpi_pkg::KEY_W,
   parameter int   NUM_STREAMS = dpi_pkg::NUM_STREAMS,
   parameter logic DEFAULT_EN  = 1'b1,
   localparam int  SID_W       = $clog2(NUM_STREAMS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [7:0]       in_data,
   input  logic             in_sop,
   input  logic             in_eop,
   input  logic [KEY_W-1:0] in_key,
   input  logic             cfg_we,
   input  logic [SID_W-1:0] cfg_sid,
   input  logic             cfg_en,
   output logic             load_state,
   output logic             new_stream_id,
   output logic [SID_W-1:0] stream_id,
   output logic             enable,
   output logic [7:0]       char_in,
   output logic             char_in_vld,
   output logic             eop,
   output logic [15:0]      err_cnt
);
   import dpi_pkg::*;

   state_t                 r_state;
   logic [KEY_W-1:0]       r_key;
   logic                   r_load_state;
   logic                   r_new;
   logic [SID_W-1:0]       r_sid;
   logic                   r_enable;
   logic                   r_eop;
   logic [15:0]            r_err_cnt;
   logic [NUM_STREAMS-1:0] r_en;

   logic                   w_hit;
   logic [SID_W-1:0]       w_hit_sid;
   logic [SID_W-1:0]       w_alloc_sid;
   logic [SID_W-1:0]       w_lookup_sid;
   logic                   w_lookup_en;
   logic                   w_tbl_we;
   logic                   w_in_rdy;
   logic [7:0]             w_char_in;
   logic                   w_char_vld;

   stream_key_table #(
      .KEY_W       (KEY_W),
      .NUM_STREAMS (NUM_STREAMS)
   ) u_key_table (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_key       (r_key),
      .o_hit       (w_hit),
      .o_hit_sid   (w_hit_sid),
      .o_alloc_sid (w_alloc_sid),
      .i_we        (w_tbl_we),
      .i_wsid      (r_sid),
      .i_wkey      (r_key)
   );

   assign w_lookup_sid = w_hit ? w_hit_sid : w_alloc_sid;

   // A cfg write landing in the LOOKUP cycle is forwarded so it still counts for this LOAD.
   assign w_lookup_en = !w_hit ? DEFAULT_EN :
                        (cfg_we && (cfg_sid == w_hit_sid)) ? cfg_en : r_en[w_hit_sid];

   assign w_tbl_we = (r_state == ST_LOAD) && r_new;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_key        <= '0;
         r_load_state <= 1'b0;
         r_new        <= 1'b0;
         r_sid        <= '0;
         r_enable     <= 1'b0;
         r_eop        <= 1'b0;
         r_err_cnt    <= '0;
      end else begin
         r_load_state <= 1'b0;
         r_eop        <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (in_vld && in_sop) begin
                  r_key   <= in_key;
                  r_state <= ST_LOOKUP;
               end else if (in_vld && (r_err_cnt != 16'hFFFF)) begin
                  r_err_cnt <= r_err_cnt + 16'd1;
               end
            end
            ST_LOOKUP: begin
               r_load_state <= 1'b1;
               r_new        <= ~w_hit;
               r_sid        <= w_lookup_sid;
               r_enable     <= w_lookup_en;
               r_state      <= ST_LOAD;
            end
            ST_LOAD:   r_state <= ST_GAP;
            ST_GAP:    r_state <= ST_STREAM;
            ST_STREAM: begin
               if (in_vld && in_eop) begin
                  r_eop   <= 1'b1;
                  r_state <= ST_EOP;
               end
            end
            ST_EOP:    r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   // Allocation is written after cfg so it wins on a same-sid collision.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_en <= {NUM_STREAMS{DEFAULT_EN}};
      end else begin
         if (cfg_we)
            r_en[cfg_sid] <= cfg_en;
         if (w_tbl_we)
            r_en[r_sid] <= DEFAULT_EN;
      end
   end

   always_comb begin
      w_in_rdy   = 1'b0;
      w_char_in  = '0;
      w_char_vld = 1'b0;
      case (r_state)
         ST_IDLE:   w_in_rdy = in_vld & ~in_sop;
         ST_STREAM: begin
            w_in_rdy   = 1'b1;
            w_char_in  = in_data;
            w_char_vld = in_vld;
         end
         default:   w_in_rdy = 1'b0;
      endcase
   end

   assign in_rdy        = w_in_rdy;
   assign char_in       = w_char_in;
   assign char_in_vld   = w_char_vld;
   assign load_state    = r_load_state;
   assign new_stream_id = r_new;
   assign stream_id     = r_sid;
   assign enable        = r_enable;
   assign eop           = r_eop;
   assign err_cnt       = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dpi_stream_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dpi_stream_dispatch : randomized bench with a key-table model      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dpi_stream_dispatch;

   localparam int NS = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_vld, in_sop, in_eop;
   logic        in_rdy;
   logic [7:0]  in_data;
   logic [31:0] in_key;
   logic        cfg_we, cfg_en;
   logic [5:0]  cfg_sid;
   logic        load_state, new_stream_id, enable, char_in_vld, eop;
   logic [5:0]  stream_id;
   logic [7:0]  char_in;
   logic [15:0] err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: list of (valid, key) slots, round-robin victim, enables.
   logic [31:0] m_key [NS];
   bit          m_vld [NS];
   bit          m_en  [NS];
   int          m_ptr;
   int          exp_err;

   dpi_stream_dispatch #(
      .KEY_W       (32),
      .NUM_STREAMS (NS),
      .DEFAULT_EN  (1'b1)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_vld        (in_vld),
      .in_rdy        (in_rdy),
      .in_data       (in_data),
      .in_sop        (in_sop),
      .in_eop        (in_eop),
      .in_key        (in_key),
      .cfg_we        (cfg_we),
      .cfg_sid       (cfg_sid),
      .cfg_en        (cfg_en),
      .load_state    (load_state),
      .new_stream_id (new_stream_id),
      .stream_id     (stream_id),
      .enable        (enable),
      .char_in       (char_in),
      .char_in_vld   (char_in_vld),
      .eop           (eop),
      .err_cnt       (err_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         m_vld[i] = 1'b0;
         m_en[i]  = 1'b1;
         m_key[i] = '0;
      end
      m_ptr   = 0;
      exp_err = 0;
   endtask

   task automatic model_lookup(input logic [31:0] key, output logic [5:0] sid,
                               output logic is_new, output logic en);
      int found = -1;
      for (int i = 0; i < NS; i++)
         if (m_vld[i] && m_key[i] == key) found = i;
      if (found >= 0) begin
         sid = 6'(found); is_new = 1'b0; en = m_en[found];
      end else begin
         sid = 6'(m_ptr); is_new = 1'b1; en = 1'b1;
         m_vld[m_ptr] = 1'b1; m_key[m_ptr] = key; m_en[m_ptr] = 1'b1;
         m_ptr = (m_ptr + 1) % NS;
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rdy"},  in_rdy, 0);
      chk({tag, "_ld"},   load_state, 0);
      chk({tag, "_new"},  new_stream_id, 0);
      chk({tag, "_sid"},  stream_id, 0);
      chk({tag, "_en"},   enable, 0);
      chk({tag, "_chr"},  char_in, 0);
      chk({tag, "_cvld"}, char_in_vld, 0);
      chk({tag, "_eop"},  eop, 0);
      chk({tag, "_err"},  err_cnt, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; cfg_we = 1'b0;
      end
   endtask

   task automatic cfg_write(input logic [5:0] s, input logic v);
      tick();
      in_vld = 1'b0; cfg_we = 1'b1; cfg_sid = s; cfg_en = v;
      m_en[s] = v;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic send_junk();
      tick();
      in_vld = 1'b1; in_sop = 1'b0; in_eop = 1'($urandom); in_data = 8'($urandom);
      cfg_we = 1'b0;
      @(negedge clk);
      chk("junk_rdy", in_rdy, 1);
      chk("junk_cvld", char_in_vld, 0);
      if (exp_err < 16'hFFFF) exp_err++;
   endtask

   task automatic send_pkt(input logic [31:0] key, input int len, input int bub_pct,
                           input bit do_cfg, input logic [5:0] cs, input logic ce);
      logic [7:0] data [$];
      logic [5:0] esid;
      logic       enew, een;
      model_lookup(key, esid, enew, een);
      for (int i = 0; i < len; i++) data.push_back(8'($urandom));

      tick();
      in_vld = 1'b1; in_sop = 1'b1; in_eop = (len == 1); in_data = data[0];
      in_key = key; cfg_we = 1'b0;
      @(negedge clk);
      chk("sop_rdy", in_rdy, 0);
      chk("sop_eop", eop, 0);
      chk("sop_err", err_cnt, exp_err);

      tick();
      @(negedge clk);
      chk("lkp_ld", load_state, 0);
      chk("lkp_rdy", in_rdy, 0);

      tick();
      @(negedge clk);
      chk("load_ld", load_state, 1);
      chk("load_new", new_stream_id, enew);
      chk("load_sid", stream_id, esid);
      chk("load_en", enable, een);

      tick();
      @(negedge clk);
      chk("gap_ld", load_state, 0);
      chk("gap_rdy", in_rdy, 0);
      chk("gap_cvld", char_in_vld, 0);

      for (int i = 0; i < len; i++) begin
         if (i > 0) begin
            for (int b = 0; b < 3 && ($urandom_range(99) < bub_pct); b++) begin
               tick();
               in_vld = 1'b0; in_data = 8'($urandom); cfg_we = 1'b0;
               @(negedge clk);
               chk("bub_cvld", char_in_vld, 0);
               chk("bub_rdy", in_rdy, 1);
            end
         end
         tick();
         in_vld = 1'b1; in_sop = (i == 0); in_eop = (i == len - 1); in_data = data[i];
         if (do_cfg && i == 0) begin
            cfg_we = 1'b1; cfg_sid = cs; cfg_en = ce;
         end else begin
            cfg_we = 1'b0;
         end
         @(negedge clk);
         chk("chr_vld", char_in_vld, 1);
         chk("chr_dat", char_in, data[i]);
         chk("chr_rdy", in_rdy, 1);
         chk("chr_sid", stream_id, esid);
         chk("chr_en", enable, een);
         chk("chr_eop", eop, 0);
      end
      if (do_cfg) m_en[cs] = ce;

      tick();
      in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; cfg_we = 1'b0;
      @(negedge clk);
      chk("eop_eop", eop, 1);
      chk("eop_cvld", char_in_vld, 0);
      chk("eop_rdy", in_rdy, 0);
      chk("eop_sid", stream_id, esid);
      chk("eop_en", enable, een);
   endtask

   initial begin
      logic [31:0] pool [$];
      rst_n = 1'b0; in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
      in_key = '0; cfg_we = 1'b0; cfg_sid = '0; cfg_en = 1'b0;
      model_reset();
      repeat (3) tick();
      @(negedge clk);
      check_all_zero("rst");
      rst_n = 1'b1;

      send_pkt(32'hAAAA0001, 3, 0, 0, 0, 0);
      send_pkt(32'hAAAA0001, 2, 0, 0, 0, 0);
      send_pkt(32'hB0000001, 2, 0, 0, 0, 0);
      send_pkt(32'hB0000002, 2, 0, 0, 0, 0);
      send_pkt(32'hB0000003, 2, 0, 0, 0, 0);
      cfg_write(6'd3, 1'b0);
      send_pkt(32'hB0000003, 3, 0, 1, 6'd3, 1'b1);
      send_pkt(32'hB0000003, 1, 0, 0, 0, 0);

      send_junk();
      send_junk();
      idle(1);
      @(negedge clk);
      chk("err_two", err_cnt, 16'(exp_err));

      send_pkt(32'hD0000001, 1, 0, 0, 0, 0);
      send_pkt(32'hD0000001, 5, 60, 0, 0, 0);

      for (int i = 0; i < 60; i++)
         send_pkt(32'hC0000000 + 32'(i), 1, 0, 0, 0, 0);
      send_pkt(32'hAAAA0001, 2, 0, 0, 0, 0);

      pool = '{32'hAAAA0001, 32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hD0000001};
      for (int i = 0; i < 70; i++) pool.push_back(32'hC0000000 + 32'(i));
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(99) < 20) send_junk();
         if ($urandom_range(99) < 15) idle($urandom_range(1, 3));
         send_pkt(pool[$urandom_range(pool.size() - 1)], $urandom_range(1, 5), 30,
                  ($urandom_range(99) < 25), 6'($urandom), 1'($urandom));
      end

      send_pkt(32'hAAAA0001, 1, 0, 0, 0, 0);
      tick();
      in_vld = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_data = 8'h5A; in_key = 32'hAAAA0001;
      repeat (4) tick();
      in_vld = 1'b1; in_sop = 1'b0; in_data = 8'h11;
      tick();
      rst_n = 1'b0; in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      tick();
      @(negedge clk);
      check_all_zero("midrst");
      rst_n = 1'b1;
      model_reset();
      send_pkt(32'hAAAA0001, 2, 0, 0, 0, 0);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dpi_stream_dispatch.md
# dpi_stream_dispatch

Front-end stage of the packet-inspection pipeline. Accepts a byte stream from the packet parser, maps each packet's flow key to a 6-bit stream ID through a 64-entry key table, and drives the per-regex matcher wrappers with the control sequence they need: load/restore state, stream ID, new-stream flag, enable, gated characters, and end-of-packet. One instance feeds all matcher wrappers in parallel.

## Interface
- KEY_W, 32, flow-key width.
- NUM_STREAMS, 64, table entries (stream ID width SID_W = 6).
- DEFAULT_EN, 1, enable value installed for a newly allocated stream.

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_vld  in  1  input beat valid
- in_rdy  out  1  input beat accepted when in_vld & in_rdy
- in_data  in  8  packet byte
- in_sop  in  1  first beat of packet
- in_eop  in  1  last beat of packet (may coincide with in_sop)
- in_key  in  KEY_W  flow key, valid on the sop beat
- cfg_we  in  1  write per-stream enable
- cfg_sid  in  SID_W  stream to configure
- cfg_en  in  1  enable value
- load_state  out  1  one-cycle pulse: matchers reset flags, restore state
- new_stream_id  out  1  qualifies load_state: stream freshly allocated
- stream_id  out  SID_W  current stream
- enable  out  1  per-stream enable for matchers
- char_in  out  8  character to matchers
- char_in_vld  out  1  character valid
- eop  out  1  one-cycle pulse after last character
- err_cnt  out  16  dropped non-sop beats in IDLE, saturating

## Operation
- FSM states: IDLE, LOOKUP, LOAD, GAP, STREAM, EOP.
- IDLE: in_rdy=0 when in_vld & in_sop (beat held, key captured, -> LOOKUP). in_vld & ~in_sop: in_rdy=1, beat dropped, err_cnt++ (saturate at 0xFFFF).
- LOOKUP: parallel compare captured key against all valid entries. Hit -> sid = matching index, new=0. Miss -> sid = alloc pointer, new=1.
- LOAD: load_state=1, new_stream_id=new, stream_id/enable registered. On miss: entry[sid] <= {valid=1, key}, en[sid] <= DEFAULT_EN, alloc pointer +1 mod NUM_STREAMS. Table full: round-robin overwrite; evicted stream restarts via new_stream_id=1.
- GAP: one idle cycle covering matcher state-restore latency.
- STREAM: in_rdy=1; char_in=in_data, char_in_vld=in_vld. Beat with in_eop accepted -> EOP.
- EOP: eop=1, char_in_vld=0, in_rdy=0; -> IDLE.
- stream_id and enable held constant from LOAD through EOP.
- cfg write takes effect at the next LOAD; cfg to the active sid never changes the in-flight enable. cfg write and miss allocation to same sid in same cycle: allocation wins.
- A hit never modifies the table; keys are unique by construction.

## Timing
- Reset values: in_rdy 0, load_state 0, new_stream_id 0, stream_id 0, enable 0, char_in 0, char_in_vld 0, eop 0, err_cnt 0; all table valid bits 0; alloc pointer 0; en[] = DEFAULT_EN; FSM IDLE.
- sop presented at cycle 0: LOOKUP cycle 1, load_state cycle 2, GAP cycle 3, first char_in_vld cycle 4 at earliest.
- eop exactly one cycle after the cycle carrying the last char_in_vld.
- Minimum packet-to-packet spacing: 6 cycles for single-byte packets (sop through EOP, next sop seen in IDLE).
- in_vld bubbles in STREAM propagate as char_in_vld gaps; no buffering, zero added latency.
- Reset mid-packet: FSM to IDLE, outputs to reset values, table invalidated next cycle; partial packet lost, no eop issued.

## Structure
- Shared package dpi_pkg: SID_W, NUM_STREAMS, KEY_W defaults, FSM state enum.
- Sub-module stream_key_table: valid/key arrays, parallel comparator, hit/index, round-robin alloc pointer, write port. Enable array and FSM stay in top.

## Test plan
- Key 0xAAAA0001 first packet, 3 bytes -> load_state cycle 2, new_stream_id=1, stream_id=0, chars cycles 4-6, eop cycle 7.
- Same key again -> new_stream_id=0, stream_id=0; table unchanged, pointer stays 1.
- 65 distinct keys -> 65th gets stream_id=0, new=1; original key then misses, gets stream_id=1, new=1.
- cfg_we sid=3 cfg_en=0, then packet allocated to sid 3 -> enable=0 throughout; cfg during an active sid-3 packet leaves enable unchanged until next LOAD.
- in_vld bubbles plus sop&eop single-byte packet -> char_in_vld mirrors beats, eop one cycle after last char; two non-sop beats in IDLE -> err_cnt=2.
- rst_n low during STREAM -> all outputs 0 next cycle, next packet with prior key gets new_stream_id=1, stream_id=0.
